// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU batch sequencer.
// The sentinel constant is only used when ALU_SEQ_SENTINEL_EN is defined.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_A,
        CAP_A,
        RD_B,
        CAP_B,
        RD_OP,
        CAP_OP,
        EXEC,
        WR,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SEL_A,
        SEL_B,
        SEL_OP
    } fetch_sel_e;

    localparam int DEF_OPND_BASE = 0;
    localparam int DEF_OP_BASE   = 100;
    localparam int DEF_RES_BASE  = 200;

    // Sign-extended to the operand width at the point of use
    localparam int SENTINEL_VAL  = -1;

endpackage

// File: rtl/alu_batch_sequencer_addr_gen.sv
// Combinational RAM address generator: operand/opcode fetch address and result address.
// All address arithmetic wraps modulo 2^AW.
module seq_addr_gen
    import alu_seq_pkg::*;
#(
    parameter int AW        = 8,
    parameter int CW        = 8,
    parameter int OPND_BASE = DEF_OPND_BASE,
    parameter int OP_BASE   = DEF_OP_BASE,
    parameter int RES_BASE  = DEF_RES_BASE
) (
    input  logic [CW-1:0] index,
    input  fetch_sel_e    sel,
    output logic [AW-1:0] fetch_addr,
    output logic [AW-1:0] res_addr
);

    logic [AW-1:0] idx;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [AW-1:0] op_addr;

    assign idx      = AW'(index);
    assign a_addr   = AW'(OPND_BASE) + (idx << 1);
    assign b_addr   = a_addr + AW'(1);
    assign op_addr  = AW'(OP_BASE) + idx;
    assign res_addr = AW'(RES_BASE) + idx;

    always_comb begin
        fetch_addr = a_addr;
        case (sel)
            SEL_B:   fetch_addr = b_addr;
            SEL_OP:  fetch_addr = op_addr;
            default: fetch_addr = a_addr;
        endcase
    end

endmodule

// File: rtl/alu_batch_sequencer.sv
// Batch RAM->ALU->RAM sequencer with start/busy/done handshake and result counter.
// Optional all-ones operand-A stop enabled by defining ALU_SEQ_SENTINEL_EN.
module alu_batch_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 8,
    parameter int OPW       = 5,
    parameter int CW        = 8,
    parameter int OPND_BASE = DEF_OPND_BASE,
    parameter int OP_BASE   = DEF_OP_BASE,
    parameter int RES_BASE  = DEF_RES_BASE
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [CW-1:0]  op_count,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  result_cnt,
    output logic [AW-1:0]  rd_addr,
    input  logic [DW-1:0]  rd_data,
    output logic           we,
    output logic [AW-1:0]  wr_addr,
    output logic [DW-1:0]  wr_data,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_out
);

    state_e        state, state_nxt;
    logic [CW-1:0] index, index_inc, count_lat, gen_index;
    fetch_sel_e    gen_sel;
    logic [AW-1:0] fetch_addr, res_addr;

    assign index_inc = index + CW'(1);

    // Addresses are prepared one state early so rd_addr is valid on entry to RD_x
    always_comb begin
        gen_index = index;
        gen_sel   = SEL_A;
        case (state)
            IDLE:    gen_index = '0;
            WR:      gen_index = index_inc;
            CAP_A:   gen_sel   = SEL_B;
            CAP_B:   gen_sel   = SEL_OP;
            default: gen_sel   = SEL_A;
        endcase
    end

    seq_addr_gen #(
        .AW        (AW),
        .CW        (CW),
        .OPND_BASE (OPND_BASE),
        .OP_BASE   (OP_BASE),
        .RES_BASE  (RES_BASE)
    ) u_addr_gen (
        .index      (gen_index),
        .sel        (gen_sel),
        .fetch_addr (fetch_addr),
        .res_addr   (res_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (op_count == '0) ? DONE : RD_A;
            RD_A:    state_nxt = CAP_A;
`ifdef ALU_SEQ_SENTINEL_EN
            CAP_A:   state_nxt = (rd_data == DW'(SENTINEL_VAL)) ? DONE : RD_B;
`else
            CAP_A:   state_nxt = RD_B;
`endif
            RD_B:    state_nxt = CAP_B;
            CAP_B:   state_nxt = RD_OP;
            RD_OP:   state_nxt = CAP_OP;
            CAP_OP:  state_nxt = EXEC;
            EXEC:    state_nxt = WR;
            WR:      state_nxt = (index_inc == count_lat) ? DONE : RD_A;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index      <= '0;
            count_lat  <= '0;
            result_cnt <= '0;
            rd_addr    <= '0;
            we         <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
        end else begin
            we <= (state == EXEC);
            case (state)
                IDLE: if (start) begin
                    count_lat  <= op_count;
                    index      <= '0;
                    result_cnt <= '0;
                    rd_addr    <= fetch_addr;
                end
                CAP_A: begin
                    alu_a   <= rd_data;
                    rd_addr <= fetch_addr;
                end
                CAP_B: begin
                    alu_b   <= rd_data;
                    rd_addr <= fetch_addr;
                end
                CAP_OP:  alu_op <= rd_data[OPW-1:0];
                EXEC: begin
                    wr_data <= alu_out;
                    wr_addr <= res_addr;
                end
                WR: begin
                    result_cnt <= result_cnt + CW'(1);
                    index      <= index_inc;
                    rd_addr    <= fetch_addr;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

endmodule
